// File: rtl/soc_optimsoc_configuration.sv
// soc_optimsoc_configuration
// Shared register map of the tile configuration space. The configuration
// reader and the responder both take their offsets and CONF bit positions
// from here, so the two sides always agree on the layout.
// Contents:
//   REG_*            byte offsets of the scalar registers and the CT list base
//   CONF_*_BIT       bit positions inside the CONF register
//   CT_LIST_MAX      largest number of compute-tile entries a reader will fetch
package soc_optimsoc_configuration;

   localparam logic [15:0] REG_TILEID   = 16'h0000;
   localparam logic [15:0] REG_NUMTILES = 16'h0004;
   localparam logic [15:0] REG_CONF     = 16'h000C;
   localparam logic [15:0] REG_COREBASE = 16'h0010;
   localparam logic [15:0] REG_NUMCTS   = 16'h0028;
   localparam logic [15:0] REG_CTLIST   = 16'h0200;

   localparam int CONF_MPSIMPLE_BIT = 0;
   localparam int CONF_DMA_BIT      = 1;

   localparam logic [6:0] CT_LIST_MAX = 7'd64;

endpackage

// File: rtl/soc_network_adapter_configuration_reader.sv
// soc_network_adapter_configuration_reader
// Scans the tile configuration space after a start pulse. It reads five
// scalar registers (tile id, tile count, conf, core base, compute-tile count),
// then fetches the compute-tile list one 16-bit entry at a time and hands
// each entry to a consumer.
//
// Handshake on the ct_* stream: an entry transfers on a rising clk edge
// where ct_valid and ct_ready are both 1. While ct_valid=1 and ct_ready=0,
// ct_tile/ct_index/ct_last are held and no bus access is issued.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle pulse; begins a scan when idle
//   bus_*               single-outstanding request bus; bus_stb is held with a
//                       stable bus_adr until ack/err/rty arrives
//   tile_id .. num_cts  registers captured by the last scan
//   ct_*                compute-tile entry stream (valid/ready)
//   busy, done, error   scan status; done is a one-cycle pulse, error is sticky
//
// Reading data uses bus_data_i[31:0], so DW must be at least 32.
module soc_network_adapter_configuration_reader
   import soc_optimsoc_configuration::*;
#(
   parameter int DW        = 32,
   parameter int MAX_RETRY = 4,
   parameter int TIMEOUT   = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          bus_stb,
   output logic [15:0]   bus_adr,
   output logic          bus_we,
   output logic [DW-1:0] bus_data_o,
   input  logic [DW-1:0] bus_data_i,
   input  logic          bus_ack,
   input  logic          bus_rty,
   input  logic          bus_err,
   output logic [31:0]   tile_id,
   output logic [31:0]   num_tiles,
   output logic          conf_mpsimple,
   output logic          conf_dma,
   output logic [31:0]   core_base,
   output logic [6:0]    num_cts,
   output logic          ct_valid,
   input  logic          ct_ready,
   output logic [15:0]   ct_tile,
   output logic [5:0]    ct_index,
   output logic          ct_last,
   output logic          busy,
   output logic          done,
   output logic          error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      GAP    = 3'd2,
      STREAM = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int RW = $clog2(MAX_RETRY + 1) + 1;
   localparam int TW = $clog2(TIMEOUT + 1) + 1;

   // Scalar index 0..4 walks the scalar registers; 5 means "in the list".
   localparam logic [2:0] SIDX_LIST = 3'd5;

   state_t        state;
   logic [2:0]    sidx;
   logic [5:0]    ent_idx;
   logic [RW-1:0] rty_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          finish;    // next GAP goes to DONE (empty compute-tile list)
   logic [31:0]   rd;
   logic [6:0]    nc_sat;
   logic          in_list;

   assign rd      = bus_data_i[31:0];
   assign nc_sat  = (rd > 32'd64) ? CT_LIST_MAX : rd[6:0];
   assign in_list = (sidx == SIDX_LIST);

   assign bus_stb    = (state == REQ);
   assign bus_we     = 1'b0;
   assign bus_data_o = '0;
   assign ct_valid   = (state == STREAM);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // Address is a function of the indices only, so it cannot move while a
   // request is outstanding: the indices change only on a response.
   always_comb begin
      bus_adr = REG_CTLIST + {9'd0, ent_idx, 1'b0};
      case (sidx)
         3'd0:    bus_adr = REG_TILEID;
         3'd1:    bus_adr = REG_NUMTILES;
         3'd2:    bus_adr = REG_CONF;
         3'd3:    bus_adr = REG_COREBASE;
         3'd4:    bus_adr = REG_NUMCTS;
         default: bus_adr = REG_CTLIST + {9'd0, ent_idx, 1'b0};
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         sidx          <= 3'd0;
         ent_idx       <= 6'd0;
         rty_cnt       <= '0;
         tmo_cnt       <= '0;
         finish        <= 1'b0;
         error         <= 1'b0;
         tile_id       <= 32'd0;
         num_tiles     <= 32'd0;
         conf_mpsimple <= 1'b0;
         conf_dma      <= 1'b0;
         core_base     <= 32'd0;
         num_cts       <= 7'd0;
         ct_tile       <= 16'd0;
         ct_index      <= 6'd0;
         ct_last       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= REQ;
                  error   <= 1'b0;
                  sidx    <= 3'd0;
                  ent_idx <= 6'd0;
                  rty_cnt <= '0;
                  tmo_cnt <= '0;
                  finish  <= 1'b0;
               end
            end
            REQ: begin
               // err outranks ack, ack outranks rty
               if (bus_err) begin
                  error <= 1'b1;
                  state <= DONE;
               end else if (bus_ack) begin
                  rty_cnt <= '0;
                  tmo_cnt <= '0;
                  if (in_list) begin
                     // Even entries sit in the upper half of the word.
                     ct_tile  <= ent_idx[0] ? rd[15:0] : rd[31:16];
                     ct_index <= ent_idx;
                     ct_last  <= ({1'b0, ent_idx} == (num_cts - 7'd1));
                     state    <= STREAM;
                  end else begin
                     case (sidx)
                        3'd0: tile_id   <= rd;
                        3'd1: num_tiles <= rd;
                        3'd2: begin
                           conf_mpsimple <= rd[CONF_MPSIMPLE_BIT];
                           conf_dma      <= rd[CONF_DMA_BIT];
                        end
                        3'd3: core_base <= rd;
                        default: begin
                           num_cts <= nc_sat;
                           finish  <= (nc_sat == 7'd0);
                        end
                     endcase
                     sidx  <= sidx + 3'd1;
                     state <= GAP;
                  end
               end else if (bus_rty) begin
                  tmo_cnt <= '0;
                  if (rty_cnt == RW'(MAX_RETRY)) begin
                     error <= 1'b1;
                     state <= DONE;
                  end else begin
                     rty_cnt <= rty_cnt + 1'b1;
                     state   <= GAP;
                  end
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  error <= 1'b1;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GAP: begin
               state <= finish ? DONE : REQ;
            end
            STREAM: begin
               if (ct_ready) begin
                  if (ct_last) begin
                     state <= DONE;
                  end else begin
                     ent_idx <= ent_idx + 6'd1;
                     state   <= GAP;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_network_adapter_configuration_reader.sv
// Directed bench for soc_network_adapter_configuration_reader with a
// scripted configuration-space responder and an entry scoreboard.
module tb_soc_network_adapter_configuration_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        bus_stb;
   logic [15:0] bus_adr;
   logic        bus_we;
   logic [31:0] bus_data_o;
   logic [31:0] bus_data_i = '0;
   logic        bus_ack = 1'b0;
   logic        bus_rty = 1'b0;
   logic        bus_err = 1'b0;
   logic [31:0] tile_id;
   logic [31:0] num_tiles;
   logic        conf_mpsimple;
   logic        conf_dma;
   logic [31:0] core_base;
   logic [6:0]  num_cts;
   logic        ct_valid;
   logic        ct_ready = 1'b1;
   logic [15:0] ct_tile;
   logic [5:0]  ct_index;
   logic        ct_last;
   logic        busy;
   logic        done;
   logic        error;

   soc_network_adapter_configuration_reader #(
      .DW(32), .MAX_RETRY(4), .TIMEOUT(256)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .bus_stb(bus_stb), .bus_adr(bus_adr), .bus_we(bus_we),
      .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
      .bus_ack(bus_ack), .bus_rty(bus_rty), .bus_err(bus_err),
      .tile_id(tile_id), .num_tiles(num_tiles),
      .conf_mpsimple(conf_mpsimple), .conf_dma(conf_dma),
      .core_base(core_base), .num_cts(num_cts),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_tile(ct_tile),
      .ct_index(ct_index), .ct_last(ct_last),
      .busy(busy), .done(done), .error(error)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- responder model ----------------
   logic [31:0] r_tile, r_ntiles, r_conf, r_core, r_ncts;
   logic [15:0] ent [0:127];
   logic [15:0] rty_adr, err_adr, hang_adr;
   int          rty_left, list_reads, hang_cnt;

   // Word-addressed: entry 2k is the upper half and 2k+1 the lower half of
   // the word at 0x200 + 4k.
   function automatic logic [31:0] mem_rd(input logic [15:0] a);
      logic [15:0] w;
      int          k;
      w = a & 16'hFFFC;
      if (w >= 16'h0200) begin
         k = int'((w - 16'h0200) >> 2);
         return {ent[2*k], ent[2*k+1]};
      end
      case (w)
         16'h0000: return r_tile;
         16'h0004: return r_ntiles;
         16'h000C: return r_conf;
         16'h0010: return r_core;
         16'h0028: return r_ncts;
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge clk) begin
      bus_ack    = 1'b0;
      bus_rty    = 1'b0;
      bus_err    = 1'b0;
      bus_data_i = '0;
      if (rst && bus_stb) begin
         if (bus_adr >= 16'h0200) list_reads++;
         if (bus_adr == err_adr) bus_err = 1'b1;
         else if (bus_adr == hang_adr) hang_cnt++;
         else if (bus_adr == rty_adr && rty_left > 0) begin
            bus_rty = 1'b1;
            rty_left--;
         end else begin
            bus_ack    = 1'b1;
            bus_data_i = mem_rd(bus_adr);
         end
      end
   end

   // ---------------- scoreboard / consumer ----------------
   logic [22:0] exp_q[$];   // {last, index, tile}
   logic [22:0] mon_e;
   int          popped, stall_idx, stall_rem, done_cnt;

   initial begin
      popped = 0; stall_idx = 0; stall_rem = 0; done_cnt = 0;
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      ct_ready = 1'b1;
      if (rst && ct_valid) begin
         if (exp_q.size() == 0) begin
            check("ct_extra_entry", 64'(exp_q.size()), 64'd1);
         end else if (stall_rem > 0 && int'(ct_index) == stall_idx) begin
            ct_ready = 1'b0;
            stall_rem--;
            check("stall_entry", {ct_last, ct_index, ct_tile}, exp_q[0]);
            check("stall_no_bus", bus_stb, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            popped++;
            check("ct_entry", {ct_last, ct_index, ct_tile}, mon_e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic setup_default();
      r_tile = 32'd3; r_ntiles = 32'd4; r_conf = 32'h3; r_core = 32'd6; r_ncts = 32'd3;
      for (int j = 0; j < 128; j++) ent[j] = 16'd0;
      ent[0] = 16'd3; ent[1] = 16'd2; ent[2] = 16'd1;
      rty_adr = 16'hFFFF; err_adr = 16'hFFFF; hang_adr = 16'hFFFF;
      rty_left = 0; list_reads = 0; hang_cnt = 0;
      stall_rem = 0; popped = 0;
      exp_q.delete();
   endtask

   task automatic push_exp(input int n);
      logic [22:0] v;
      for (int i = 0; i < n; i++) begin
         v = {(i == n - 1) ? 1'b1 : 1'b0, 6'(i), ent[i]};
         exp_q.push_back(v);
      end
   endtask

   task automatic run_scan(input int budget);
      int cyc;
      int d0;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check("scan_done", done, 1'b1);
      repeat (3) @(negedge clk);
      check("done_pulses", 64'(done_cnt - d0), 64'd1);
      check("idle_after", busy, 1'b0);
   endtask

   task automatic check_zero();
      check("rst_stb", bus_stb, 0);         check("rst_adr", bus_adr, 0);
      check("rst_ct_valid", ct_valid, 0);   check("rst_ct_tile", ct_tile, 0);
      check("rst_ct_index", ct_index, 0);   check("rst_ct_last", ct_last, 0);
      check("rst_busy", busy, 0);           check("rst_done", done, 0);
      check("rst_error", error, 0);         check("rst_tile_id", tile_id, 0);
      check("rst_num_tiles", num_tiles, 0); check("rst_mpsimple", conf_mpsimple, 0);
      check("rst_dma", conf_dma, 0);        check("rst_core_base", core_base, 0);
      check("rst_num_cts", num_cts, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc;
      setup_default();
      repeat (3) @(negedge clk);
      check_zero();
      check("rst_we", bus_we, 0);
      check("rst_data_o", bus_data_o, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // basic scan
      setup_default();
      push_exp(3);
      run_scan(200);
      check("t1_tile_id", tile_id, 32'd3);
      check("t1_num_tiles", num_tiles, 32'd4);
      check("t1_mpsimple", conf_mpsimple, 1'b1);
      check("t1_dma", conf_dma, 1'b1);
      check("t1_core_base", core_base, 32'd6);
      check("t1_num_cts", num_cts, 7'd3);
      check("t1_error", error, 1'b0);
      check("t1_entries", 64'(popped), 64'd3);

      // consumer stalls entry 1 for 10 cycles
      setup_default();
      stall_idx = 1; stall_rem = 10;
      push_exp(3);
      run_scan(300);
      check("t2_stall_used", 64'(stall_rem), 64'd0);
      check("t2_entries", 64'(popped), 64'd3);
      check("t2_error", error, 1'b0);

      // four retries then ack at 0x04
      setup_default();
      r_ntiles = 32'h55; rty_adr = 16'h0004; rty_left = 4;
      push_exp(3);
      run_scan(300);
      check("t3_num_tiles", num_tiles, 32'h55);
      check("t3_error", error, 1'b0);
      check("t3_rty_used", 64'(rty_left), 64'd0);
      check("t3_entries", 64'(popped), 64'd3);

      // five retries at 0x04 abort; num_tiles keeps the previous capture
      setup_default();
      r_ntiles = 32'h77; rty_adr = 16'h0004; rty_left = 5;
      run_scan(300);
      check("t4_error", error, 1'b1);
      check("t4_list_reads", 64'(list_reads), 64'd0);
      check("t4_num_tiles_kept", num_tiles, 32'h55);
      check("t4_entries", 64'(popped), 64'd0);

      // err on first list read
      setup_default();
      err_adr = 16'h0200;
      run_scan(300);
      check("t5_error", error, 1'b1);
      check("t5_entries", 64'(popped), 64'd0);
      check("t5_num_cts", num_cts, 7'd3);

      // no response at 0x10 -> timeout
      setup_default();
      hang_adr = 16'h0010;
      run_scan(1000);
      check("t5b_error", error, 1'b1);
      check("t5b_wait_cycles", 64'(hang_cnt), 64'd256);
      check("t5b_list_reads", 64'(list_reads), 64'd0);

      // 100 compute tiles saturate to 64
      setup_default();
      r_ncts = 32'd100;
      for (int j = 0; j < 128; j++) ent[j] = 16'h1000 + 16'(j);
      push_exp(64);
      run_scan(2000);
      check("t6_num_cts", num_cts, 7'd64);
      check("t6_entries", 64'(popped), 64'd64);
      check("t6_error", error, 1'b0);

      // reset in the middle of the list, then a clean rescan
      setup_default();
      r_ncts = 32'd100;
      for (int j = 0; j < 128; j++) ent[j] = 16'h2000 + 16'(j);
      push_exp(64);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (popped < 5 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("t7_mid_list", popped >= 5, 1'b1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check_zero();
      @(negedge clk);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      setup_default();
      push_exp(3);
      run_scan(300);
      check("t7_tile_id", tile_id, 32'd3);
      check("t7_num_cts", num_cts, 7'd3);
      check("t7_entries", 64'(popped), 64'd3);
      check("t7_error", error, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
